// File: rtl/down_counter_if.sv
// Load handshake and status bundle for down_counter.
// The counter uses the slave modport. The controller that loads it and reads its status uses the master modport.
interface down_counter_if #(
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_val;
  logic             auto_rl;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_val, auto_rl,
    input  load_ready, count, tc, busy, done
  );

  modport slave (
    input  load_valid, load_val, auto_rl,
    output load_ready, count, tc, busy, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer: one-cycle tc pulse at zero or at reload. count and tc are registered; load_ready drops while running.
// Optional prescaler on the decrement qualifier, enabled by DOWN_CNT_PRESCALE_EN (adds the pre_div port).
module down_counter #(
  parameter int WIDTH = 32
`ifdef DOWN_CNT_PRESCALE_EN
  , parameter int PRE_WIDTH = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
`ifdef DOWN_CNT_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] pre_div,
`endif
  down_counter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_reg;
  logic             auto_reg;
  logic             tc_q;
  logic             ld;
  logic             tick;

  assign bus.load_ready = (state != RUN);
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == EXPIRE);
  assign bus.count      = count_q;
  assign bus.tc         = tc_q;

  assign ld = bus.load_valid & bus.load_ready;

`ifdef DOWN_CNT_PRESCALE_EN
  logic [PRE_WIDTH-1:0] pre_cnt;

  assign tick = en & (pre_cnt == pre_div);

  // Prescaler only runs while counting; any exit or restart realigns it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (clr || ld || state != RUN) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  assign tick = en;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count_q    <= '0;
      reload_reg <= '0;
      auto_reg   <= 1'b0;
      tc_q       <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (ld) begin
      reload_reg <= bus.load_val;
      if (bus.load_val != '0) begin
        auto_reg <= bus.auto_rl;
        count_q  <= bus.load_val;
        state    <= RUN;
        tc_q     <= 1'b0;
      end else begin
        // A zero load expires immediately and can never auto-reload.
        auto_reg <= 1'b0;
        count_q  <= '0;
        state    <= EXPIRE;
        tc_q     <= 1'b1;
      end
    end else if (state == RUN && tick) begin
      if (count_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
        tc_q <= 1'b1;
        if (auto_reg) begin
          count_q <= reload_reg;
        end else begin
          count_q <= '0;
          state   <= EXPIRE;
        end
      end else begin
        count_q <= count_q - 1'b1;
        tc_q    <= 1'b0;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Directed and random stimulus for down_counter, checked each cycle against a timer model.
// The model tracks remaining enabled ticks and the armed/expired status.
module tb_down_counter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, clr, en;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state.
  bit m_active, m_expired, m_repeat, m_tc;
  int m_left, m_period, m_pre, m_pdiv;

  down_counter_if #(.WIDTH(W)) ifc ();

`ifdef DOWN_CNT_PRESCALE_EN
  logic [7:0] pre_div;
  down_counter #(.WIDTH(W), .PRE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .pre_div(pre_div), .bus(ifc.slave)
  );
`else
  down_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .bus(ifc.slave)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic cyc(input logic r, input logic c, input logic e, input logic lv,
                     input logic [W-1:0] v, input logic a);
    bit tick;
    rst = r; clr = c; en = e;
    ifc.load_valid = lv; ifc.load_val = v; ifc.auto_rl = a;
`ifdef DOWN_CNT_PRESCALE_EN
    pre_div = m_pdiv[7:0];
`endif
    tick = e && (m_pre == m_pdiv);
    if (!r) begin
      m_active = 0; m_expired = 0; m_repeat = 0; m_tc = 0;
      m_left = 0; m_period = 0; m_pre = 0;
    end else if (c) begin
      m_active = 0; m_expired = 0; m_left = 0; m_tc = 0; m_pre = 0;
    end else if (lv && !m_active) begin
      m_period = int'(v); m_pre = 0;
      if (v == 0) begin
        m_active = 0; m_expired = 1; m_repeat = 0; m_tc = 1; m_left = 0;
      end else begin
        m_active = 1; m_expired = 0; m_repeat = a; m_tc = 0; m_left = int'(v);
      end
    end else if (m_active && e) begin
      if (tick) begin
        m_pre = 0;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_tc = 1;
          if (m_repeat) m_left = m_period;
          else begin m_active = 0; m_expired = 1; end
        end else m_tc = 0;
      end else begin
        m_pre = m_pre + 1; m_tc = 0;
      end
    end else begin
      m_tc = 0;
      if (!m_active) m_pre = 0;
    end
    @(posedge clk); #1;
    chk("count", 32'(ifc.count), 32'(m_left));
    chk("tc", 32'(ifc.tc), 32'(m_tc));
    chk("busy", 32'(ifc.busy), 32'(m_active));
    chk("done", 32'(ifc.done), 32'(m_expired));
    chk("load_ready", 32'(ifc.load_ready), 32'(!m_active));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b0;
    ifc.load_valid = 1'b0; ifc.load_val = '0; ifc.auto_rl = 1'b0;
    m_pdiv = 0;
`ifdef DOWN_CNT_PRESCALE_EN
    pre_div = '0;
`endif
    @(negedge clk);

    // Reset held with a load pending: nothing must be taken.
    cyc(0, 0, 1, 1, 8'd9, 1);
    cyc(0, 0, 1, 1, 8'd9, 1);

    // One-shot from 5.
    cyc(1, 0, 1, 1, 8'd5, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, 0, 8'd0, 0);

    // Auto-reload of 3 with enable gaps and ignored loads while busy.
    cyc(1, 0, 0, 1, 8'd3, 1);
    for (int i = 0; i < 12; i++) cyc(1, 0, (i % 4) != 1, 1, 8'd7, 0);

    // Zero load, then reload coincident with the tc pulse.
    cyc(1, 1, 0, 0, 8'd0, 0);
    cyc(1, 0, 1, 1, 8'd0, 1);
    cyc(1, 0, 0, 1, 8'd2, 0);
    cyc(1, 0, 1, 0, 8'd0, 0);
    cyc(1, 0, 1, 0, 8'd0, 0);

    // Abort at count 7 with a simultaneous load request.
    cyc(1, 0, 0, 1, 8'd10, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 8'd0, 0);
    cyc(1, 1, 1, 1, 8'd4, 0);
    cyc(1, 0, 0, 0, 8'd0, 0);

    // Reset mid-run.
    cyc(1, 0, 1, 1, 8'd6, 1);
    cyc(1, 0, 1, 0, 8'd0, 0);
    cyc(0, 0, 1, 0, 8'd0, 0);
    cyc(1, 0, 1, 0, 8'd0, 0);

`ifdef DOWN_CNT_PRESCALE_EN
    // Divide by three: count steps every third enabled cycle.
    m_pdiv = 2;
    cyc(1, 0, 1, 1, 8'd2, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 8'd0, 0);
    m_pdiv = $urandom_range(0, 2);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 49) != 0), logic'($urandom_range(0, 24) == 0),
          logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
          W'($urandom_range(0, 6)), logic'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter/timer; complements the team's up_counter, which counts up from a cleared value, by counting down from a loaded value to zero.
- Accepts a start value over a valid/ready load handshake and decrements on each enabled cycle.
- Signals terminal count with a one-cycle pulse and optionally auto-reloads.
- Used as the programmable interval/timeout source for controller FSMs in the same design.

Parameters:
- WIDTH, 32, counter and load-value width in bits (>=2).
- PRE_WIDTH, 8, prescaler width in bits; used only with DOWN_CNT_PRESCALE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset; rst=0 at a rising clk edge resets the block.
- clr  input  1  synchronous abort to IDLE.
- en  input  1  count enable (decrement qualifier).
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_val  input  WIDTH  start/reload value.
- auto_rl  input  1  auto-reload mode, sampled on load accept.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle).
- busy  output  1  high in RUN.
- done  output  1  high in EXPIRE.

Behaviour:
- Reset (rst=0): state=IDLE, count=0, reload_reg=0, auto_reg=0, tc=0. load_ready=1, busy=0, done=0.
- Priority per edge: rst > clr > load accept > decrement.
- States: IDLE, RUN, EXPIRE. busy=(state==RUN), done=(state==EXPIRE), load_ready=(state!=RUN); all three are combinational from state.
- clr=1: next state=IDLE, count=0, tc=0. Applies in any state; aborts RUN mid-count.
- Load accept = load_valid & load_ready at an edge:
  - Captures reload_reg=load_val and auto_reg=auto_rl.
  - If load_val!=0: count=load_val, state=RUN, tc=0.
  - If load_val==0: count=0, state=EXPIRE, tc=1 next cycle; auto_reg is forced to 0.
- load_valid while in RUN is ignored (load_ready=0); no queuing.
- RUN, en=0: count, state and tc hold; tc=0.
- RUN, en=1, count>1: count=count-1, tc=0.
- RUN, en=1, count==1:
  - tc=1 for exactly the following cycle.
  - auto_reg=0: count=0, state=EXPIRE.
  - auto_reg=1: count=reload_reg, state stays RUN. Period is reload_reg enabled cycles.
- tc is high in the same cycle count first shows 0 (one-shot) or the reload value (auto). It deasserts the next cycle unless re-triggered.
- EXPIRE: count holds 0 until load accept (re-arm) or clr. en is ignored.
- IDLE: en is ignored; count holds 0.
- Load accepted in EXPIRE on the cycle tc=1: the new load takes effect and tc drops next cycle.
- No wrap-around: count never decrements below 0. Subtraction is WIDTH-bit, guarded by the count==1 check.
- Reset mid-RUN: immediate return to reset values at that edge.

Optional Feature:
- Macro DOWN_CNT_PRESCALE_EN.
- Defined:
  - Adds input port pre_div [PRE_WIDTH-1:0] and an internal PRE_WIDTH prescaler.
  - The decrement qualifier becomes en & (pre_cnt==pre_div); pre_cnt resets to 0 on every qualifying tick.
  - pre_cnt increments only when en=1 in RUN, and clears on rst, clr, load accept and exit from RUN.
  - pre_div=0 behaves identically to the undefined build.
- Undefined: no pre_div port and no prescaler logic; every en=1 cycle in RUN decrements.

Test Plan:
- Reset: hold rst=0 for 2 cycles with load_valid=1 -> count=0, tc=0, load_ready=1, busy=0, done=0; no load accepted.
- One-shot: load_val=5, auto_rl=0, en=1 continuously -> count 5,4,3,2,1,0; tc=1 only in the cycle count=0 (5 cycles after accept); then done=1, busy=0, count holds 0.
- Auto-reload with gaps: load_val=3, auto_rl=1, en toggling 1,0,1,1 -> count holds during en=0; tc pulses every 3rd enabled cycle with count=3 on the pulse; stays busy; load_valid ignored while busy.
- Edge loads: load_val=0 -> done=1, tc=1 the next cycle, auto ignored. Then in EXPIRE load_val=2 with load_valid coincident with tc -> RUN with count=2, tc low next cycle.
- Abort/priority: in RUN at count=7, assert clr and load_valid together -> IDLE, count=0, tc=0, load not taken. Assert rst=0 mid-RUN -> reset values next edge.
- With DOWN_CNT_PRESCALE_EN, pre_div=2, load_val=2, en=1 -> count changes every 3 cycles; tc fires 6 cycles after accept.
